// File: rtl/wb_data_arbiter_pkg.sv
// Shared constants and FSM state type for the Wishbone data-port arbiter.
package wb_data_arbiter_pkg;

    localparam int ARB_MASTERS = 4;
    localparam int ARB_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wb_data_arbiter_if.sv
// Bundle of CPU-side and RAM-side Wishbone signals around the data arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding CPUs and RAM.
interface wb_data_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int AW = 16
);
    logic [N-1:0]    m_cyc_i;
    logic [N-1:0]    m_stb_i;
    logic [N-1:0]    m_we_i;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N-1:0]    m_ack_o;
    logic [N-1:0]    m_err_o;
    logic [DW-1:0]   m_dat_o;
    logic            s_cyc_o;
    logic            s_stb_o;
    logic            s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic            s_ack_i;
    logic [DW-1:0]   s_dat_i;
    logic [1:0]      grant_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o,
               s_dat_o, grant_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o,
               s_dat_o, grant_o
    );

endinterface

// File: rtl/wb_data_arbiter_rr_picker.sv
// Round-robin picker: first requesting index at or above ptr, wrapping mod N.
module wb_data_arbiter_rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [1:0]   gnt_idx,
    output logic         any
);

    logic       found;
    logic [2:0] pos;

    // Walk the masters starting at ptr; the first requester found wins.
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + 3'(i);
            if (pos >= 3'(N)) begin
                pos = pos - 3'(N);
            end
            if (!found && req[pos[1:0]]) begin
                gnt_idx = pos[1:0];
                found   = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/wb_data_arbiter.sv
// Round-robin arbiter sharing the RAM/ROM Wishbone data slave between the
// CPU load/store units: one transfer at a time, a recovery cycle after each
// transfer to swallow the slave's stale registered ack, and an ack timeout.
module wb_data_arbiter
    import wb_data_arbiter_pkg::*;
#(
    parameter int N       = ARB_MASTERS,
    parameter int DW      = 32,
    parameter int AW      = 16,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input logic             clk,
    input logic             rst,
    wb_data_arbiter_if.slave bus
);

    arb_state_e  state, state_nxt;
    logic [1:0]  grant, grant_nxt;
    logic [1:0]  rr_ptr, rr_nxt;
    logic [7:0]  tmo_cnt, tmo_nxt;
    logic [N-1:0] req;
    logic [1:0]  pick_idx;
    logic        pick_any;

    assign req = bus.m_cyc_i & bus.m_stb_i;

    wb_data_arbiter_rr_picker #(.N(N)) u_picker (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // State, grant, round-robin pointer and timeout counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr_ptr  <= rr_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    // Next-state logic plus slave-side drive and master-side ack/err steering.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        rr_nxt      = rr_ptr;
        tmo_nxt     = tmo_cnt;
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_idx;
                    tmo_nxt   = '0;
                    state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                bus.s_cyc_o = 1'b1;
                bus.s_stb_o = 1'b1;
                bus.s_we_o  = bus.m_we_i[grant];
                bus.s_adr_o = bus.m_adr_i[int'(grant)*AW +: AW];
                bus.s_dat_o = bus.m_dat_i[int'(grant)*DW +: DW];
                tmo_nxt     = tmo_cnt + 8'd1;
                // Abort outranks ack, ack outranks timeout.
                if (!bus.m_cyc_i[grant]) begin
                    state_nxt = ARB_DONE;
                end else if (bus.s_ack_i) begin
                    bus.m_ack_o[grant] = 1'b1;
                    state_nxt          = ARB_DONE;
                end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                    bus.m_err_o[grant] = 1'b1;
                    state_nxt          = ARB_DONE;
                end
            end
            ARB_DONE: begin
                rr_nxt    = (grant == 2'(N - 1)) ? '0 : grant + 2'd1;
                state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.grant_o = grant;

endmodule

// File: tb/tb_wb_data_arbiter.sv
// Self-checking bench for wb_data_arbiter: directed scenarios plus random
// request rounds checked against a transaction-level round-robin model.
module tb_wb_data_arbiter;

    localparam int N       = 4;
    localparam int DW      = 32;
    localparam int AW      = 16;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;
    logic slave_en;

    int errors = 0;
    int checks = 0;
    int mptr;  // model round-robin pointer

    logic [AW-1:0] r_adr [N];
    logic [DW-1:0] r_dat [N];
    logic          r_we  [N];

    always #5 clk = ~clk;

    wb_data_arbiter_if #(.N(N), .DW(DW), .AW(AW)) bus ();

    wb_data_arbiter #(.N(N), .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
        return (a == 16'h0010) ? 32'hDEADBEEF : {~a, a};
    endfunction

    // Zero-wait RAM model: registered ack, held while cyc&stb is held.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.s_ack_i <= 1'b0;
            bus.s_dat_i <= '0;
        end else begin
            bus.s_ack_i <= bus.s_cyc_o & bus.s_stb_o & slave_en;
            bus.s_dat_i <= slave_data(bus.s_adr_o);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int k);
        bus.m_cyc_i[k] = 1'b1;
        bus.m_stb_i[k] = 1'b1;
        bus.m_we_i[k]  = r_we[k];
        bus.m_adr_i[k*AW +: AW] = r_adr[k];
        bus.m_dat_i[k*DW +: DW] = r_dat[k];
    endtask

    task automatic drop(input int k);
        bus.m_cyc_i[k] = 1'b0;
        bus.m_stb_i[k] = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        slave_en    = 1'b1;
        mptr        = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    // All masters in mask request together in cycle 0 and each drops after
    // its ack; the model predicts service order and per-cycle bus activity.
    task automatic run_round(input logic [N-1:0] mask, input string name);
        int order[$];
        logic [N-1:0] rem;
        logic [N-1:0] exp_ack;
        int p, cnt, drop_k, j, kk;
        logic busy;
        rem = mask;
        p   = mptr;
        while (rem != '0) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (p + i) % N;
                if (rem[k]) begin
                    order.push_back(k);
                    rem[k] = 1'b0;
                    p = (k + 1) % N;
                    break;
                end
            end
        end
        mptr   = p;
        cnt    = order.size();
        drop_k = -1;
        for (int c = 0; c <= 4 * cnt; c++) begin
            step();
            if (c == 0) begin
                for (int k = 0; k < N; k++) if (mask[k]) raise(k);
            end
            if (drop_k >= 0) begin
                drop(drop_k);
                drop_k = -1;
            end
            #1;
            j    = (c >= 1) ? (c - 1) / 4 : 0;
            busy = (c >= 1) && (j < cnt) && (((c - 1) % 4) < 2);
            kk   = order[j];
            exp_ack = '0;
            if (busy && ((c - 1) % 4) == 1) exp_ack[kk] = 1'b1;
            checks++;
            if (bus.m_ack_o !== exp_ack) begin
                errors++;
                $display("FAIL %s ack c=%0d: got %b want %b", name, c, bus.m_ack_o, exp_ack);
            end
            checks++;
            if (bus.m_err_o !== '0) begin
                errors++;
                $display("FAIL %s err c=%0d: got %b want 0", name, c, bus.m_err_o);
            end
            checks++;
            if ({bus.s_cyc_o, bus.s_stb_o} !== {busy, busy}) begin
                errors++;
                $display("FAIL %s cyc/stb c=%0d: got %b%b want %b", name, c,
                         bus.s_cyc_o, bus.s_stb_o, busy);
            end
            if (busy) begin
                checks++;
                if (bus.grant_o !== 2'(kk) || bus.s_we_o !== r_we[kk] ||
                    bus.s_adr_o !== r_adr[kk] || bus.s_dat_o !== r_dat[kk]) begin
                    errors++;
                    $display("FAIL %s slave mux c=%0d: got g=%0d we=%b adr=%h dat=%h want g=%0d we=%b adr=%h dat=%h",
                             name, c, bus.grant_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o,
                             kk, r_we[kk], r_adr[kk], r_dat[kk]);
                end
            end
            if (exp_ack != '0) begin
                checks++;
                if (bus.m_dat_o !== slave_data(r_adr[kk])) begin
                    errors++;
                    $display("FAIL %s rdata c=%0d: got %h want %h", name, c,
                             bus.m_dat_o, slave_data(r_adr[kk]));
                end
                drop_k = kk;
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b000 || bus.s_adr_o !== '0 ||
            bus.s_dat_o !== '0 || bus.m_ack_o !== '0 || bus.m_err_o !== '0 ||
            bus.grant_o !== 2'd0) begin
            errors++;
            $display("FAIL %s outputs: got cyc=%b stb=%b we=%b adr=%h dat=%h ack=%b err=%b g=%0d want all 0",
                     name, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o,
                     bus.m_ack_o, bus.m_err_o, bus.grant_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        slave_en = 1'b1;
        bus.m_cyc_i = 4'b0001;
        bus.m_stb_i = 4'b0001;
        bus.m_we_i  = 4'b0001;
        bus.m_adr_i = '1;
        bus.m_dat_i = '1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        r_adr[1] = 16'h0010;
        r_we[1]  = 1'b0;
        r_dat[1] = 32'h0;
        run_round(4'b0010, "single_read");
    endtask

    task automatic test_all_four();
        do_reset();
        for (int k = 0; k < N; k++) begin
            r_adr[k] = 16'h0100 + 16'(k * 4);
            r_we[k]  = 1'b0;
            r_dat[k] = 32'h0;
        end
        run_round(4'b1111, "all_four");
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_ack;
        do_reset();
        r_adr[0] = 16'h0200; r_we[0] = 1'b0; r_dat[0] = 32'h0;
        r_adr[2] = 16'h0300; r_we[2] = 1'b0; r_dat[2] = 32'h0;
        for (int c = 0; c <= 11; c++) begin
            step();
            if (c == 0) raise(0);
            if (c == 1) raise(2);
            if (c == 7) drop(2);
            #1;
            exp_ack = (c == 2 || c == 10) ? 4'b0001 : (c == 6) ? 4'b0100 : 4'b0000;
            checks++;
            if (bus.m_ack_o !== exp_ack) begin
                errors++;
                $display("FAIL fairness ack c=%0d: got %b want %b", c, bus.m_ack_o, exp_ack);
            end
        end
        drop(0);
    endtask

    task automatic test_write();
        do_reset();
        r_adr[3] = 16'h1004;
        r_we[3]  = 1'b1;
        r_dat[3] = 32'h12345678;
        run_round(4'b1000, "write");
    endtask

    task automatic test_timeout();
        logic [N-1:0] exp_err;
        logic exp_stb;
        do_reset();
        slave_en = 1'b0;
        r_adr[0] = 16'h0020; r_we[0] = 1'b0; r_dat[0] = 32'h0;
        for (int c = 0; c <= 17; c++) begin
            step();
            if (c == 0) raise(0);
            if (c == 16) drop(0);
            #1;
            exp_err = (c == TIMEOUT) ? 4'b0001 : 4'b0000;
            exp_stb = (c >= 1) && (c <= TIMEOUT);
            checks++;
            if (bus.m_err_o !== exp_err || bus.m_ack_o !== '0 || bus.s_stb_o !== exp_stb) begin
                errors++;
                $display("FAIL timeout c=%0d: got err=%b ack=%b stb=%b want err=%b ack=0000 stb=%b",
                         c, bus.m_err_o, bus.m_ack_o, bus.s_stb_o, exp_err, exp_stb);
            end
        end
        slave_en = 1'b1;
    endtask

    task automatic test_abort();
        do_reset();
        r_adr[1] = 16'h0040; r_we[1] = 1'b0; r_dat[1] = 32'h0;
        for (int c = 0; c <= 3; c++) begin
            step();
            if (c == 0) raise(1);
            if (c == 1) drop(1);
            #1;
            checks++;
            if (bus.m_ack_o !== '0 || bus.m_err_o !== '0 || bus.s_stb_o !== (c == 1)) begin
                errors++;
                $display("FAIL abort c=%0d: got ack=%b err=%b stb=%b want ack=0000 err=0000 stb=%b",
                         c, bus.m_ack_o, bus.m_err_o, bus.s_stb_o, (c == 1));
            end
        end
        mptr = 2;
        r_adr[0] = 16'h0050; r_we[0] = 1'b0; r_dat[0] = 32'h0;
        r_adr[3] = 16'h0060; r_we[3] = 1'b1; r_dat[3] = 32'hA5A5A5A5;
        run_round(4'b1001, "after_abort");
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        r_adr[2] = 16'h0ABC; r_we[2] = 1'b1; r_dat[2] = 32'hCAFEF00D;
        step();
        raise(2);
        step();
        #1;
        checks++;
        if (bus.s_stb_o !== 1'b1 || bus.s_we_o !== 1'b1 || bus.grant_o !== 2'd2) begin
            errors++;
            $display("FAIL mid_busy pre: got stb=%b we=%b g=%0d want stb=1 we=1 g=2",
                     bus.s_stb_o, bus.s_we_o, bus.grant_o);
        end
        #1 rst = 1'b0;
        #1;
        check_all_zero("mid_busy_reset");
        drop(2);
        @(posedge clk);
        #2 rst = 1'b1;
        mptr = 0;
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        do_reset();
        for (int r = 0; r < 8; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < N; k++) begin
                r_adr[k] = 16'($urandom);
                r_we[k]  = 1'($urandom);
                r_dat[k] = $urandom;
            end
            run_round(mask, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_all_four();
        test_fairness();
        test_write();
        test_timeout();
        test_abort();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
